// File: rtl/pwm_mc_pkg.sv
// pwm_mc_pkg
// Shared definitions for the multi-channel PWM generator.
//   pwm_mode_e  : per-channel alignment mode encoding (reserved code decodes as left)
//   chan_cfg_t  : per-channel shadowed control bits (enable, polarity, mode)
package pwm_mc_pkg;

    typedef enum logic [1:0] {
        MODE_LEFT  = 2'b00,
        MODE_RIGHT = 2'b01,
        MODE_UNAL  = 2'b10,
        MODE_RSVD  = 2'b11
    } pwm_mode_e;

    typedef struct packed {
        logic      en;
        logic      pol;
        pwm_mode_e mode;
    } chan_cfg_t;

endpackage

// File: rtl/pwm_gen_mc_if.sv
// pwm_gen_mc_if
// Configuration bus between the peripheral register file (master) and the
// multi-channel PWM generator (slave).
//   cfg_period/cfg_updown        : time base setup
//   cfg_ch_en/cfg_mode/cfg_pol   : per-channel control, one bit (two for mode) per channel
//   cfg_cmp1/cfg_cmp2            : per-channel compares, channel i at [i*CW +: CW]
//   cfg_load                     : single-cycle capture request
//   cfg_ack                      : single-cycle pulse when captured values become active
interface pwm_gen_mc_if #(
    parameter int NCH = 4,
    parameter int CW  = 16
);
    logic [CW-1:0]      cfg_period;
    logic               cfg_updown;
    logic [NCH-1:0]     cfg_ch_en;
    logic [2*NCH-1:0]   cfg_mode;
    logic [NCH-1:0]     cfg_pol;
    logic [NCH*CW-1:0]  cfg_cmp1;
    logic [NCH*CW-1:0]  cfg_cmp2;
    logic               cfg_load;
    logic               cfg_ack;

    modport master (
        output cfg_period, cfg_updown, cfg_ch_en, cfg_mode, cfg_pol,
               cfg_cmp1, cfg_cmp2, cfg_load,
        input  cfg_ack
    );

    modport slave (
        input  cfg_period, cfg_updown, cfg_ch_en, cfg_mode, cfg_pol,
               cfg_cmp1, cfg_cmp2, cfg_load,
        output cfg_ack
    );
endinterface

// File: rtl/pwm_mc_chan.sv
// pwm_mc_chan
// One PWM channel: decodes the shared counter against this channel's active
// compares and registers the result.
//   clk, rst_n : clock, async active-low reset
//   tick       : counter enable; the output register holds while low
//   cnt        : shared counter value
//   cfg        : active enable/polarity/mode
//   cmp1, cmp2 : active compare values (cmp2 used by unaligned mode only)
//   pwm        : registered output, one cycle behind cnt
module pwm_mc_chan
    import pwm_mc_pkg::*;
#(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tick,
    input  logic [CW-1:0] cnt,
    input  chan_cfg_t     cfg,
    input  logic [CW-1:0] cmp1,
    input  logic [CW-1:0] cmp2,
    output logic          pwm
);
    logic raw;

    // Unaligned with cmp1 >= cmp2 naturally yields an empty window.
    always_comb begin
        raw = 1'b0;
        case (cfg.mode)
            MODE_RIGHT: raw = (cnt >= cmp1);
            MODE_UNAL:  raw = (cnt >= cmp1) && (cnt < cmp2);
            default:    raw = (cnt < cmp1);
        endcase
    end

    // A disabled channel parks at its idle level, which is the polarity bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm <= 1'b0;
        end else if (tick) begin
            pwm <= cfg.en ? (raw ^ cfg.pol) : cfg.pol;
        end
    end
endmodule

// File: rtl/pwm_gen_mc.sv
// pwm_gen_mc
// Multi-channel PWM generator with a shared up or up/down time base and
// double-buffered per-channel configuration applied at period boundaries.
//   clk, rst_n   : clock, async active-low reset
//   run          : counter enable; 0 freezes counter, outputs and active stage
//   bus          : configuration interface (slave side), incl. cfg_load/cfg_ack
//   cnt_val      : current counter value
//   period_start : high in the cycle the counter shows the 0 opening a period
//   pwm_out      : per-channel PWM outputs
module pwm_gen_mc
    import pwm_mc_pkg::*;
#(
    parameter int NCH = 4,
    parameter int CW  = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           run,
    pwm_gen_mc_if.slave    bus,
    output logic [CW-1:0]  cnt_val,
    output logic           period_start,
    output logic [NCH-1:0] pwm_out
);
    localparam logic [CW-1:0] ZERO = '0;
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0]         act_period;
    logic                  act_updown;
    chan_cfg_t [NCH-1:0]   act_ch;
    logic [NCH*CW-1:0]     act_cmp1;
    logic [NCH*CW-1:0]     act_cmp2;

    logic [CW-1:0]         pend_period;
    logic                  pend_updown;
    chan_cfg_t [NCH-1:0]   pend_ch;
    logic [NCH*CW-1:0]     pend_cmp1;
    logic [NCH*CW-1:0]     pend_cmp2;
    logic                  pend_valid;

    chan_cfg_t [NCH-1:0]   in_ch;
    logic                  dir_down;
    logic                  first_cycle;
    logic                  ack_q;
    logic [CW-1:0]         cnt_next;
    logic                  dir_next;
    logic                  boundary;

    assign bus.cfg_ack = ack_q;

    always_comb begin
        in_ch = '0;
        for (int i = 0; i < NCH; i++) begin
            in_ch[i].en   = bus.cfg_ch_en[i];
            in_ch[i].pol  = bus.cfg_pol[i];
            in_ch[i].mode = pwm_mode_e'(bus.cfg_mode[2*i +: 2]);
        end
    end

    // Next counter value assuming no boundary. A boundary is simply any run
    // cycle whose successor value is 0, which also covers P = 0 and the
    // up/down P = 1 case where the top turns straight back to 0.
    always_comb begin
        cnt_next = ZERO;
        dir_next = 1'b0;
        if (act_period == ZERO) begin
            cnt_next = ZERO;
        end else if (!act_updown) begin
            cnt_next = (cnt_val >= act_period) ? ZERO : cnt_val + ONE;
        end else if (!dir_down) begin
            if (cnt_val >= act_period) begin
                cnt_next = act_period - ONE;
                dir_next = 1'b1;
            end else begin
                cnt_next = cnt_val + ONE;
            end
        end else begin
            cnt_next = (cnt_val <= ONE) ? ZERO : cnt_val - ONE;
            dir_next = (cnt_val > ONE);
        end
    end

    assign boundary = run && (first_cycle || (cnt_next == ZERO));

    // A load in the same cycle as a boundary lands in the pending stage after
    // the boundary has already sampled it, so it waits for the next boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_val      <= ZERO;
            dir_down     <= 1'b0;
            first_cycle  <= 1'b1;
            period_start <= 1'b0;
            ack_q        <= 1'b0;
            act_period   <= ZERO;
            act_updown   <= 1'b0;
            act_ch       <= '0;
            act_cmp1     <= '0;
            act_cmp2     <= '0;
            pend_period  <= ZERO;
            pend_updown  <= 1'b0;
            pend_ch      <= '0;
            pend_cmp1    <= '0;
            pend_cmp2    <= '0;
            pend_valid   <= 1'b0;
        end else begin
            period_start <= boundary;
            ack_q        <= boundary && pend_valid;

            if (run) begin
                first_cycle <= 1'b0;
                if (boundary) begin
                    cnt_val  <= ZERO;
                    dir_down <= 1'b0;
                    if (pend_valid) begin
                        act_period <= pend_period;
                        act_updown <= pend_updown;
                        act_ch     <= pend_ch;
                        act_cmp1   <= pend_cmp1;
                        act_cmp2   <= pend_cmp2;
                    end
                end else begin
                    cnt_val  <= cnt_next;
                    dir_down <= dir_next;
                end
            end

            if (bus.cfg_load) begin
                pend_period <= bus.cfg_period;
                pend_updown <= bus.cfg_updown;
                pend_ch     <= in_ch;
                pend_cmp1   <= bus.cfg_cmp1;
                pend_cmp2   <= bus.cfg_cmp2;
                pend_valid  <= 1'b1;
            end else if (boundary) begin
                pend_valid  <= 1'b0;
            end
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        pwm_mc_chan #(.CW(CW)) u_chan (
            .clk  (clk),
            .rst_n(rst_n),
            .tick (run),
            .cnt  (cnt_val),
            .cfg  (act_ch[i]),
            .cmp1 (act_cmp1[i*CW +: CW]),
            .cmp2 (act_cmp2[i*CW +: CW]),
            .pwm  (pwm_out[i])
        );
    end
endmodule
